execute_unit: RTL and testbench

- Parametrised successor of the single-cycle execute stage.
- Registered execute unit with valid/ready handshakes on input (from decode/regfile read) and output (to memory/writeback).
- Adds full RV32I integer ALU ops, a multi-cycle serial shifter, load/store address generation, BEQ/BNE/BLT/BGE/BLTU/BGEU and JAL/JALR with a redirect port, flush, and illegal-op flagging.

---
 rtl/execute_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_execute_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// Registered RV32I execute stage: ALU, serial shifter, LW/SW address generation,
// branch/jump resolution with a redirect pulse, flush and illegal-op flagging.
module execute_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_STEP = 1,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_op,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_r1_d,
    input  logic [XLEN-1:0] in_r2_d,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_rd_d,
    output logic            out_mem_re,
    output logic            out_mem_we,
    output logic [XLEN-1:0] out_mem_addr,
    output logic [XLEN-1:0] out_mem_wd,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [6:0] OP_ALU    = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    typedef struct packed {
        logic            rd_we;
        logic [XLEN-1:0] rd_d;
        logic            mem_re;
        logic            mem_we;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_wd;
        logic [XLEN-1:0] next_pc;
        logic            illegal;
    } res_t;

    state_t             state_q, state_d;
    res_t               res_q, res_d, dec;
    logic [4:0]         dst_q, dst_d;
    logic               valid_q, valid_d;
    logic               redir_q, redir_d;
    logic               alive_q;
    logic [XLEN-1:0]    work_q, work_d, shifted;
    logic [SHAMT_W-1:0] cnt_q, cnt_d, shamt;
    logic               left_q, left_d, arith_q, arith_d;
    logic [XLEN-1:0]    op_b, pc_inc;
    logic               dec_taken, br_cond, is_shift, accept;

    assign in_ready = alive_q & ~flush & ((state_q == IDLE) | ((state_q == FULL) & out_ready));
    assign accept   = in_valid & in_ready;

    assign op_b     = (in_op == OP_ALU) ? in_r2_d : in_imm;
    assign shamt    = op_b[SHAMT_W-1:0];
    assign pc_inc   = in_pc + XLEN'(PC_STEP);
    assign is_shift = ((in_op == OP_ALU) || (in_op == OP_IMM)) &&
                      ((in_funct3 == 3'd1) || (in_funct3 == 3'd5));
    assign shifted  = left_q ? {work_q[XLEN-2:0], 1'b0}
                             : {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};

    // Instruction decode and single-cycle result
    always_comb begin
        dec          = '0;
        dec.mem_addr = in_r1_d + in_imm;
        dec.mem_wd   = in_r2_d;
        dec.next_pc  = pc_inc;
        dec_taken    = 1'b0;
        br_cond      = 1'b0;
        case (in_op)
            OP_ALU, OP_IMM: begin
                dec.rd_we = 1'b1;
                case (in_funct3)
                    3'd0:    dec.rd_d = ((in_op == OP_ALU) && in_funct7_5) ? in_r1_d - op_b
                                                                          : in_r1_d + op_b;
                    3'd2:    dec.rd_d = XLEN'($signed(in_r1_d) < $signed(op_b));
                    3'd3:    dec.rd_d = XLEN'(in_r1_d < op_b);
                    3'd4:    dec.rd_d = in_r1_d ^ op_b;
                    3'd6:    dec.rd_d = in_r1_d | op_b;
                    3'd7:    dec.rd_d = in_r1_d & op_b;
                    default: dec.rd_d = in_r1_d;  // shifts; final only when shamt is zero
                endcase
            end
            OP_LOAD: begin
                if (in_funct3 == 3'd2) begin
                    dec.rd_we  = 1'b1;
                    dec.mem_re = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (in_funct3 == 3'd2) dec.mem_we  = 1'b1;
                else                   dec.illegal = 1'b1;
            end
            OP_JAL: begin
                dec.rd_we   = 1'b1;
                dec.rd_d    = pc_inc;
                dec.next_pc = in_pc + in_imm;
                dec_taken   = 1'b1;
            end
            OP_JALR: begin
                dec.rd_we   = 1'b1;
                dec.rd_d    = pc_inc;
                dec.next_pc = {dec.mem_addr[XLEN-1:1], 1'b0};
                dec_taken   = 1'b1;
            end
            OP_BRANCH: begin
                case (in_funct3)
                    3'd0:    br_cond = in_r1_d == in_r2_d;
                    3'd1:    br_cond = in_r1_d != in_r2_d;
                    3'd4:    br_cond = $signed(in_r1_d) <  $signed(in_r2_d);
                    3'd5:    br_cond = $signed(in_r1_d) >= $signed(in_r2_d);
                    3'd6:    br_cond = in_r1_d <  in_r2_d;
                    3'd7:    br_cond = in_r1_d >= in_r2_d;
                    default: dec.illegal = 1'b1;
                endcase
                dec_taken = br_cond;
                if (br_cond) dec.next_pc = in_pc + in_imm;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (in_rd == 5'd0) dec.rd_we = 1'b0;
    end

    // Next-state and output register values
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        dst_d   = dst_q;
        valid_d = valid_q;
        redir_d = 1'b0;
        work_d  = work_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        case (state_q)
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d    = FULL;
                    valid_d    = 1'b1;
                    res_d.rd_d = shifted;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (accept) begin
            res_d = dec;
            dst_d = in_rd;
            if (is_shift && (shamt != '0)) begin
                // Hold decoded fields in the output regs with valid low until the shift completes
                state_d = SHIFT;
                valid_d = 1'b0;
                work_d  = in_r1_d;
                cnt_d   = shamt;
                left_d  = (in_funct3 == 3'd1);
                arith_d = in_funct7_5;
            end else begin
                state_d = FULL;
                valid_d = 1'b1;
                redir_d = dec_taken;
            end
        end
        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
            redir_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            dst_q   <= '0;
            valid_q <= 1'b0;
            redir_q <= 1'b0;
            alive_q <= 1'b0;
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            dst_q   <= dst_d;
            valid_q <= valid_d;
            redir_q <= redir_d;
            alive_q <= 1'b1;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_rd         = dst_q;
    assign out_rd_we      = res_q.rd_we;
    assign out_rd_d       = res_q.rd_d;
    assign out_mem_re     = res_q.mem_re;
    assign out_mem_we     = res_q.mem_we;
    assign out_mem_addr   = res_q.mem_addr;
    assign out_mem_wd     = res_q.mem_wd;
    assign out_next_pc    = res_q.next_pc;
    assign out_illegal    = res_q.illegal;
    assign redirect_valid = redir_q;
    assign redirect_pc    = res_q.next_pc;

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: directed cases plus randomized instructions
// checked against a spec-level reference model.
module tb_execute_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_op = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7_5 = 1'b0;
    logic [31:0] in_pc = '0, in_r1_d = '0, in_r2_d = '0, in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_mem_re, out_mem_we, out_illegal, redirect_valid;
    logic [31:0] out_rd_d, out_mem_addr, out_mem_wd, out_next_pc, redirect_pc;

    always #5 clock = ~clock;

    execute_unit #(.XLEN(32), .PC_STEP(1)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct3(in_funct3),
        .in_funct7_5(in_funct7_5), .in_pc(in_pc), .in_r1_d(in_r1_d), .in_r2_d(in_r2_d),
        .in_imm(in_imm), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_rd_d(out_rd_d),
        .out_mem_re(out_mem_re), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
        .out_mem_wd(out_mem_wd), .out_next_pc(out_next_pc), .out_illegal(out_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        rd_we, mem_re, mem_we, illegal, redirect;
        logic [31:0] rd_d, mem_addr, mem_wd, next_pc;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   rdy_mode = 0, pat_i = 0;
    bit   mon_en = 1'b1, held = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: result of one instruction straight from the ISA rules
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                   input logic [31:0] pc, r1, r2, imm, input logic [4:0] rd);
        exp_t e;
        logic [31:0] b;
        int sh;
        bit t;
        e = '{rd: rd, rd_we: 0, mem_re: 0, mem_we: 0, illegal: 0, redirect: 0,
              rd_d: 0, mem_addr: r1 + imm, mem_wd: r2, next_pc: pc + 1, due: 1};
        b  = (op == 7'h33) ? r2 : imm;
        sh = int'(b % 32);
        case (op)
            7'h33, 7'h13: begin
                e.rd_we = 1;
                case (f3)
                    0: e.rd_d = (op == 7'h33 && f75) ? r1 - b : r1 + b;
                    1: e.rd_d = r1 << sh;
                    2: e.rd_d = ($signed(r1) < $signed(b)) ? 1 : 0;
                    3: e.rd_d = (r1 < b) ? 1 : 0;
                    4: e.rd_d = r1 ^ b;
                    5: e.rd_d = f75 ? 32'($signed(r1) >>> sh) : r1 >> sh;
                    6: e.rd_d = r1 | b;
                    default: e.rd_d = r1 & b;
                endcase
                if (f3 == 1 || f3 == 5) e.due = 1 + sh;
            end
            7'h03: if (f3 == 2) begin e.rd_we = 1; e.mem_re = 1; end else e.illegal = 1;
            7'h23: if (f3 == 2) e.mem_we = 1; else e.illegal = 1;
            7'h6f: begin e.rd_we = 1; e.rd_d = pc + 1; e.redirect = 1; e.next_pc = pc + imm; end
            7'h67: begin
                e.rd_we = 1; e.rd_d = pc + 1; e.redirect = 1;
                e.next_pc = (r1 + imm) & 32'hFFFF_FFFE;
            end
            7'h63: begin
                case (f3)
                    0: t = (r1 == r2);
                    1: t = (r1 != r2);
                    4: t = ($signed(r1) <  $signed(r2));
                    5: t = ($signed(r1) >= $signed(r2));
                    6: t = (r1 <  r2);
                    7: t = (r1 >= r2);
                    default: begin t = 0; e.illegal = 1; end
                endcase
                e.redirect = t;
                if (t) e.next_pc = pc + imm;
            end
            default: e.illegal = 1;
        endcase
        if (rd == 0) e.rd_we = 0;
        return e;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pop on the first valid cycle, re-check held outputs while stalled
    always @(negedge clock) begin
        if (!reset_n || !mon_en) begin
            held = 1'b0;
        end else if (out_valid) begin
            if (!held) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    cur = sbq.pop_front();
                    chk("latency", cyc, cur.due);
                    chk("redirect_valid", 32'(redirect_valid), 32'(cur.redirect));
                    if (cur.redirect) chk("redirect_pc", redirect_pc, cur.next_pc);
                end
            end else begin
                chk("redirect_once", 32'(redirect_valid), 32'd0);
            end
            chk("rd", 32'(out_rd), 32'(cur.rd));
            chk("rd_we", 32'(out_rd_we), 32'(cur.rd_we));
            if (cur.rd_we) chk("rd_d", out_rd_d, cur.rd_d);
            chk("mem_re", 32'(out_mem_re), 32'(cur.mem_re));
            chk("mem_we", 32'(out_mem_we), 32'(cur.mem_we));
            if (cur.mem_re || cur.mem_we) chk("mem_addr", out_mem_addr, cur.mem_addr);
            if (cur.mem_we) chk("mem_wd", out_mem_wd, cur.mem_wd);
            chk("next_pc", out_next_pc, cur.next_pc);
            chk("illegal", 32'(out_illegal), 32'(cur.illegal));
            held = !out_ready;
        end else begin
            held = 1'b0;
        end
    end

    // Drive one instruction (call at posedge+1); returns at posedge+1 after acceptance
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic [31:0] pc, r1, r2, imm, input logic [4:0] rd);
        exp_t e;
        bit   ok = 0;
        in_valid = 1; in_op = op; in_funct3 = f3; in_funct7_5 = f75;
        in_pc = pc; in_r1_d = r1; in_r2_d = r2; in_imm = imm; in_rd = rd;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clock);
            if (in_ready) begin
                e = model(op, f3, f75, pc, r1, r2, imm, rd);
                e.due = cyc + e.due;
                sbq.push_back(e);
                ok = 1;
            end
            @(posedge clock); #1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 0;
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] sp[5];
        sp = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int vcount;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] ops[9];
        ops = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h63};

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_rd_d", out_rd_d, 32'd0);
        chk("rst_next_pc", out_next_pc, 32'd0);
        reset_n = 1'b1;
        #1 chk("in_ready_before_clk", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        chk("in_ready_after_rel", 32'(in_ready), 32'd1);

        // Directed: overflow add, serial SRAI, zero-shift SLLI, branches, illegal
        issue(7'h33, 3'd0, 1'b0, 32'h40, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd5);
        issue(7'h13, 3'd5, 1'b1, 32'h44, 32'h8000_0000, 32'h0, 32'h4, 5'd6);
        vcount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (in_ready) vcount++;
        end
        chk("srai_in_ready_low", vcount, 0);
        @(posedge clock); #1;
        issue(7'h13, 3'd1, 1'b0, 32'h48, 32'h1234_5678, 32'h0, 32'h0, 5'd7);
        issue(7'h63, 3'd4, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFC, 5'd0);
        issue(7'h63, 3'd6, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFC, 5'd0);
        issue(7'h7F, 3'd0, 1'b0, 32'h20, 32'h5, 32'h6, 32'h7, 5'd3);
        issue(7'h67, 3'd0, 1'b0, 32'h30, 32'h101, 32'h0, 32'h2, 5'd1);

        // Back-to-back ADDI with out_ready pattern 1,0,0,1
        rdy_mode = 1;
        for (int i = 0; i < 8; i++)
            issue(7'h13, 3'd0, 1'b0, 32'(100 + i), 32'(i * 3), 32'h0, 32'(i), 5'(i + 1));
        repeat (6) @(posedge clock);
        rdy_mode = 0;
        #1;

        // Flush on the second cycle of a 10-cycle shift
        issue(7'h13, 3'd1, 1'b0, 32'h80, 32'h1, 32'h0, 32'd10, 5'd9);
        void'(sbq.pop_back());
        flush = 1'b1;
        #1 chk("in_ready_during_flush", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        flush = 1'b0;
        #1 chk("in_ready_after_flush", 32'(in_ready), 32'd1);
        vcount = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (out_valid) vcount++;
        end
        chk("flush_no_output", vcount, 0);
        @(posedge clock); #1;

        // Randomized traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 250; i++) begin
            op = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            f3 = (op == 7'h67) ? 3'd0 : 3'($urandom);
            issue(op, f3, 1'($urandom), $urandom, rnd_val(), rnd_val(),
                  ($urandom_range(0, 1) == 1) ? 32'($signed($urandom_range(0, 4095)) - 2048) : rnd_val(),
                  5'($urandom));
            repeat ($urandom_range(0, 1)) @(posedge clock);
            #0;
        end
        rdy_mode = 0;
        for (int k = 0; k < 200 && (sbq.size() != 0 || out_valid); k++) @(posedge clock);
        #1 chk("scoreboard_drained", sbq.size(), 0);

        // Asynchronous reset while holding a result
        rdy_mode = 3;
        @(posedge clock); #1;
        issue(7'h33, 3'd7, 1'b0, 32'h90, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 5'd4);
        @(negedge clock);
        chk("full_before_reset", 32'(out_valid), 32'd1);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_rd_we", 32'(out_rd_we), 32'd0);
        chk("arst_rd_d", out_rd_d, 32'd0);
        chk("arst_rd", 32'(out_rd), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_next_pc", out_next_pc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
